// File: rtl/sched_pkg.sv
// Shared types and helpers for the execution-unit issue scheduler.
package sched_pkg;

  // Op class encoding
  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_BR  = 2'b01;
  localparam logic [1:0] CLS_MEM = 2'b10;
  localparam logic [1:0] CLS_MUL = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  // Occupancy of the unit for a given class; latencies are supplied by the caller
  // because they are per-instance parameters.
  function automatic logic [3:0] lat_of(input logic [1:0] cls,
                                        input logic [3:0] alu_lat,
                                        input logic [3:0] br_lat,
                                        input logic [3:0] mem_lat,
                                        input logic [3:0] mul_lat);
    logic [3:0] lat;
    unique case (cls)
      CLS_ALU: lat = alu_lat;
      CLS_BR:  lat = br_lat;
      CLS_MEM: lat = mem_lat;
      CLS_MUL: lat = mul_lat;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               any_req
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Scan ptr, ptr+1, ... modulo NUM_REQ and keep the first hit
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
        sum = sum - (PTR_W + 1)'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fu_issue_scheduler.sv
// Issue scheduler for one shared multi-cycle execution unit.
// Round-robin picks a ready requester, holds the unit for the class latency,
// then pulses done with the tag. Flush cancels the in-flight op.
// Optional macro SCHED_STATS_EN adds saturating issue/flush/conflict counters.
module fu_issue_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned CORE      = 0,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned TAG_WIDTH = 4,
  parameter int unsigned ALU_LAT   = 1,
  parameter int unsigned BR_LAT    = 1,
  parameter int unsigned MEM_LAT   = 3,
  parameter int unsigned MUL_LAT   = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [2*NUM_REQ-1:0]         req_class,
  input  logic [TAG_WIDTH*NUM_REQ-1:0] req_tag,
  input  logic                         flush,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         issue_valid,
  output logic [1:0]                   issue_class,
  output logic [TAG_WIDTH-1:0]         issue_tag,
  output logic                         busy,
  output logic                         done_valid,
  output logic [TAG_WIDTH-1:0]         done_tag,
  input  logic                         report
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]                  stat_issued,
  output logic [31:0]                  stat_flushed,
  output logic [31:0]                  stat_conflict
`endif
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic                   issue_valid_q, issue_valid_d;
  logic [1:0]             issue_class_q, issue_class_d;
  logic [TAG_WIDTH-1:0]   issue_tag_q, issue_tag_d;
  logic                   done_valid_q, done_valid_d;
  logic [TAG_WIDTH-1:0]   done_tag_q, done_tag_d;

  logic [NUM_REQ-1:0]     winner;
  logic                   any_req;
  logic [PTR_W-1:0]       win_idx;
  logic [1:0]             win_cls;
  logic [TAG_WIDTH-1:0]   win_tag;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // Encode the one-hot winner and select its class and tag slices
  always_comb begin
    win_idx = '0;
    win_cls = '0;
    win_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) begin
        win_idx = PTR_W'(i);
        win_cls = req_class[2*i +: 2];
        win_tag = req_tag[TAG_WIDTH*i +: TAG_WIDTH];
      end
    end
  end

  // Next-state and registered-output logic; flush overrides everything
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    grant_d       = '0;
    issue_valid_d = 1'b0;
    issue_class_d = issue_class_q;
    issue_tag_d   = issue_tag_q;
    done_valid_d  = 1'b0;
    done_tag_d    = done_tag_q;

    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            grant_d       = winner;
            issue_valid_d = 1'b1;
            issue_class_d = win_cls;
            issue_tag_d   = win_tag;
            cnt_d         = lat_of(win_cls, 4'(ALU_LAT), 4'(BR_LAT), 4'(MEM_LAT),
                                   4'(MUL_LAT)) - 4'd1;
            rr_ptr_d      = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
            state_d       = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            done_valid_d = 1'b1;
            done_tag_d   = issue_tag_q;
            state_d      = ST_IDLE;
          end
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      grant_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_class_q <= '0;
      issue_tag_q   <= '0;
      done_valid_q  <= 1'b0;
      done_tag_q    <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      issue_valid_q <= issue_valid_d;
      issue_class_q <= issue_class_d;
      issue_tag_q   <= issue_tag_d;
      done_valid_q  <= done_valid_d;
      done_tag_q    <= done_tag_d;
    end
  end

  assign grant       = grant_q;
  assign issue_valid = issue_valid_q;
  assign issue_class = issue_class_q;
  assign issue_tag   = issue_tag_q;
  assign busy        = (state_q == ST_EXEC);
  assign done_valid  = done_valid_q;
  assign done_tag    = done_tag_q;

`ifdef SCHED_STATS_EN
  logic [31:0] stat_issued_q, stat_flushed_q, stat_conflict_q;

  // Saturating event counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_issued_q   <= '0;
      stat_flushed_q  <= '0;
      stat_conflict_q <= '0;
    end else begin
      if (issue_valid_q && (stat_issued_q != '1)) begin
        stat_issued_q <= stat_issued_q + 32'd1;
      end
      if (flush && (state_q == ST_EXEC) && (stat_flushed_q != '1)) begin
        stat_flushed_q <= stat_flushed_q + 32'd1;
      end
      if ((state_q == ST_IDLE) && ($countones(req) > 1) && (stat_conflict_q != '1)) begin
        stat_conflict_q <= stat_conflict_q + 32'd1;
      end
    end
  end

  assign stat_issued   = stat_issued_q;
  assign stat_flushed  = stat_flushed_q;
  assign stat_conflict = stat_conflict_q;
`endif

`ifndef SYNTHESIS
  logic [31:0] report_cyc_q;

  // Free-running cycle count used only in state dumps
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      report_cyc_q <= '0;
    end else begin
      report_cyc_q <= report_cyc_q + 32'd1;
    end
  end

  // Per-cycle state dump while report is high
  always_ff @(posedge clock) begin
    if (report) begin
      $display("[core %0d] cyc=%0d state=%s rr_ptr=%0d req=%b grant=%b cnt=%0d done=%b",
               CORE, report_cyc_q, state_q.name(), rr_ptr_q, req, grant_q, cnt_q,
               done_valid_q);
    end
  end
`endif

endmodule
